// File: rtl/aes_byte_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_byte_host                                                              |
// | Host initiator: serialises plaintext/key onto the AES engine byte bus,     |
// | issues start, and gathers the 16-byte ciphertext burst into a response.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aes_byte_host #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_pt,
    input  logic [127:0] req_key,
    input  logic         req_load_key,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_ct,
    output logic         resp_err,
    output logic [1:0]   eng_cmd,
    output logic [7:0]   eng_din,
    input  logic         eng_ready,
    input  logic [7:0]   eng_dout,
    input  logic         eng_dok
);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT_CYCLES);
    localparam logic [1:0]    C_CMD_ID  = 2'b00;
    localparam logic [1:0]    C_CMD_SP  = 2'b01;
    localparam logic [1:0]    C_CMD_SK  = 2'b10;
    localparam logic [1:0]    C_CMD_ST  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_SEND_PT  = 3'd2,
        S_SEND_KEY = 3'd3,
        S_START    = 3'd4,
        S_RECV     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t        r_state, w_state;
    logic [127:0]  r_pt, w_pt;
    logic [127:0]  r_key, w_key;
    logic [127:0]  r_ct, w_ct;
    logic          r_load_key, w_load_key;
    logic [3:0]    r_bcnt, w_bcnt;
    logic [TW-1:0] r_tcnt, w_tcnt;
    logic [TW-1:0] w_tcnt_inc;
    logic [1:0]    r_cmd, w_cmd;
    logic [7:0]    r_din, w_din;
    logic          r_req_ready, w_req_ready;
    logic          r_resp_valid, w_resp_valid;
    logic          r_resp_err, w_resp_err;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state      <= S_IDLE;
            r_pt         <= '0;
            r_key        <= '0;
            r_ct         <= '0;
            r_load_key   <= 1'b0;
            r_bcnt       <= '0;
            r_tcnt       <= '0;
            r_cmd        <= C_CMD_ID;
            r_din        <= 8'h00;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pt         <= w_pt;
            r_key        <= w_key;
            r_ct         <= w_ct;
            r_load_key   <= w_load_key;
            r_bcnt       <= w_bcnt;
            r_tcnt       <= w_tcnt;
            r_cmd        <= w_cmd;
            r_din        <= w_din;
            r_req_ready  <= w_req_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
        end
    end

    assign w_tcnt_inc = r_tcnt + TW'(1);

    // r_pt/r_key are shift registers: the byte to present next is always in [127:120].
    always_comb begin
        w_state      = r_state;
        w_pt         = r_pt;
        w_key        = r_key;
        w_ct         = r_ct;
        w_load_key   = r_load_key;
        w_bcnt       = r_bcnt;
        w_tcnt       = r_tcnt;
        w_cmd        = r_cmd;
        w_din        = r_din;
        w_req_ready  = r_req_ready;
        w_resp_valid = r_resp_valid;
        w_resp_err   = r_resp_err;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_pt        = req_pt;
                    w_key       = req_key;
                    w_load_key  = req_load_key;
                    w_ct        = '0;
                    w_resp_err  = 1'b0;
                    w_req_ready = 1'b0;
                    w_state     = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (eng_ready) begin
                    w_cmd   = C_CMD_SP;
                    w_din   = r_pt[127:120];
                    w_pt    = {r_pt[119:0], 8'h00};
                    w_bcnt  = 4'd0;
                    w_state = S_SEND_PT;
                end
            end
            S_SEND_PT: begin
                if (r_bcnt == 4'd15) begin
                    w_bcnt = 4'd0;
                    if (r_load_key) begin
                        w_cmd   = C_CMD_SK;
                        w_din   = r_key[127:120];
                        w_key   = {r_key[119:0], 8'h00};
                        w_state = S_SEND_KEY;
                    end else begin
                        w_cmd   = C_CMD_ST;
                        w_din   = 8'h00;
                        w_tcnt  = '0;
                        w_state = S_START;
                    end
                end else begin
                    w_din  = r_pt[127:120];
                    w_pt   = {r_pt[119:0], 8'h00};
                    w_bcnt = r_bcnt + 4'd1;
                end
            end
            S_SEND_KEY: begin
                if (r_bcnt == 4'd15) begin
                    w_bcnt  = 4'd0;
                    w_cmd   = C_CMD_ST;
                    w_din   = 8'h00;
                    w_tcnt  = '0;
                    w_state = S_START;
                end else begin
                    w_din  = r_key[127:120];
                    w_key  = {r_key[119:0], 8'h00};
                    w_bcnt = r_bcnt + 4'd1;
                end
            end
            S_START: begin
                if (eng_dok) begin
                    w_ct    = {r_ct[119:0], eng_dout};
                    w_cmd   = C_CMD_ID;
                    w_bcnt  = 4'd1;
                    w_state = S_RECV;
                end else if (w_tcnt_inc == C_TIMEOUT) begin
                    w_tcnt       = w_tcnt_inc;
                    w_cmd        = C_CMD_ID;
                    w_ct         = '0;
                    w_resp_err   = 1'b1;
                    w_resp_valid = 1'b1;
                    w_state      = S_DONE;
                end else begin
                    w_tcnt = w_tcnt_inc;
                end
            end
            S_RECV: begin
                if (eng_dok) begin
                    w_ct = {r_ct[119:0], eng_dout};
                    if (r_bcnt == 4'd15) begin
                        w_resp_err   = 1'b0;
                        w_resp_valid = 1'b1;
                        w_state      = S_DONE;
                    end else begin
                        w_bcnt = r_bcnt + 4'd1;
                    end
                end else begin
                    // Burst ended early: report error, keep the partial ciphertext.
                    w_resp_err   = 1'b1;
                    w_resp_valid = 1'b1;
                    w_state      = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    w_resp_valid = 1'b0;
                    w_req_ready  = 1'b1;
                    w_bcnt       = 4'd0;
                    w_tcnt       = '0;
                    w_state      = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_ct    = r_ct;
    assign resp_err   = r_resp_err;
    assign eng_cmd    = r_cmd;
    assign eng_din    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_byte_host                                                           |
// | Self-checking bench: engine-side behavioural model with random traffic.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_aes_byte_host;
    localparam int C_T = 8;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] req_pt = '0;
    logic [127:0] req_key = '0;
    logic         req_load_key = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_ct;
    logic         resp_err;
    logic [1:0]   eng_cmd;
    logic [7:0]   eng_din;
    logic         eng_ready = 1'b0;
    logic [7:0]   eng_dout = 8'h00;
    logic         eng_dok = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    aes_byte_host #(.TIMEOUT_CYCLES(C_T)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pt       (req_pt),
        .req_key      (req_key),
        .req_load_key (req_load_key),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_ct      (resp_ct),
        .resp_err     (resp_err),
        .eng_cmd      (eng_cmd),
        .eng_din      (eng_din),
        .eng_ready    (eng_ready),
        .eng_dout     (eng_dout),
        .eng_dok      (eng_dok)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs the DUT must ignore in the current state get random values.
    task automatic noise();
        eng_dok   = 1'($urandom);
        eng_dout  = 8'($urandom);
        req_valid = 1'($urandom);
        req_pt    = rand128();
        req_key   = rand128();
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int n);
        logic [127:0] t;
        t = v >> (8 * (15 - n));
        return t[7:0];
    endfunction

    // nbytes==0 means the engine never answers (timeout); abort_k>=0 resets during SK byte abort_k.
    task automatic run_txn(input logic [127:0] pt, input logic [127:0] key, input logic lk,
                           input int rdy_dly, input int dok_dly, input int nbytes,
                           input logic [127:0] burst, input int bp, input int abort_k);
        logic [127:0] exp_ct;
        logic [127:0] mask;
        logic         exp_err;
        check("req_ready_idle", {127'b0, req_ready}, 128'd1);
        req_valid    = 1'b1;
        req_pt       = pt;
        req_key      = key;
        req_load_key = lk;
        eng_ready    = (rdy_dly == 0);
        cycle();
        check("req_ready_busy", {127'b0, req_ready}, 128'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            noise();
            eng_ready = 1'b0;
            cycle();
            check("wait_cmd", {118'b0, eng_cmd, eng_din}, 128'h000);
        end
        eng_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            noise();
            cycle();
            check("sp_byte", {118'b0, eng_cmd, eng_din}, {118'b0, 2'b01, byte_of(pt, n)});
        end
        if (lk) begin
            for (int n = 0; n < 16; n++) begin
                if (n == abort_k) begin
                    rst_      = 1'b1;
                    req_valid = 1'b0;
                    cycle();
                    rst_ = 1'b0;
                    check("rst_cmd_din", {118'b0, eng_cmd, eng_din}, 128'h000);
                    check("rst_flags", {125'b0, req_ready, resp_valid, resp_err}, 128'b100);
                    check("rst_ct", resp_ct, 128'h0);
                    return;
                end
                noise();
                cycle();
                check("sk_byte", {118'b0, eng_cmd, eng_din}, {118'b0, 2'b10, byte_of(key, n)});
            end
        end
        noise();
        cycle();
        check("st_first", {118'b0, eng_cmd, eng_din}, {118'b0, 2'b11, 8'h00});
        if (nbytes == 0) begin
            for (int k = 1; k <= C_T; k++) begin
                noise();
                eng_dok = 1'b0;
                cycle();
                if (k < C_T) check("st_hold", {117'b0, resp_valid, eng_cmd, eng_din}, {117'b0, 1'b0, 2'b11, 8'h00});
            end
            exp_ct  = '0;
            mask    = {128{1'b1}};
            exp_err = 1'b1;
        end else begin
            for (int k = 0; k < dok_dly; k++) begin
                noise();
                eng_dok = 1'b0;
                cycle();
                check("st_wait", {117'b0, resp_valid, eng_cmd, eng_din}, {117'b0, 1'b0, 2'b11, 8'h00});
            end
            for (int j = 0; j < nbytes; j++) begin
                noise();
                eng_dok  = 1'b1;
                eng_dout = byte_of(burst, j);
                cycle();
                check("recv_cmd", {118'b0, eng_cmd, eng_din}, 128'h000);
                check("recv_valid", {127'b0, resp_valid}, {127'b0, (j == 15)});
            end
            if (nbytes < 16) begin
                noise();
                eng_dok = 1'b0;
                cycle();
            end
            mask    = {128{1'b1}};
            mask    = mask >> (8 * (16 - nbytes));
            exp_ct  = burst >> (8 * (16 - nbytes));
            exp_err = (nbytes < 16);
        end
        check("done_valid", {126'b0, resp_valid, req_ready}, 128'b10);
        check("done_err", {127'b0, resp_err}, {127'b0, exp_err});
        check("done_ct", resp_ct & mask, exp_ct);
        for (int b = 0; b < bp; b++) begin
            noise();
            resp_ready = 1'b0;
            cycle();
            check("bp_hold", {125'b0, resp_valid, req_ready, resp_err}, {125'b0, 1'b1, 1'b0, exp_err});
            check("bp_ct", resp_ct & mask, exp_ct);
        end
        noise();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        eng_dok    = 1'b0;
        check("consumed", {116'b0, resp_valid, req_ready, eng_cmd, eng_din}, {116'b0, 1'b0, 1'b1, 10'h000});
    endtask

    initial begin
        int nb;
        rst_ = 1'b1;
        cycle();
        cycle();
        rst_ = 1'b0;
        check("reset_cmd_din", {118'b0, eng_cmd, eng_din}, 128'h000);
        check("reset_flags", {125'b0, req_ready, resp_valid, resp_err}, 128'b100);
        check("reset_ct", resp_ct, 128'h0);

        // Full request with key load, dok 5 cycles after ST.
        run_txn(128'h00041214120412000C00131108231919, 128'h2475A2B33475568831E2120013AA5487,
                1'b1, 0, 5, 16, 128'h000102030405060708090A0B0C0D0E0F, 0, -1);
        // Key reuse.
        run_txn(rand128(), rand128(), 1'b0, 0, 2, 16, rand128(), 1, -1);
        // Engine not ready for 10 cycles.
        run_txn(rand128(), rand128(), 1'b1, 10, 0, 16, rand128(), 0, -1);
        // Timeout.
        run_txn(rand128(), rand128(), 1'b0, 0, 0, 0, 128'h0, 2, -1);
        // Short burst with backpressure.
        run_txn(rand128(), rand128(), 1'b1, 0, 3, 10, 128'hAAABACADAEAFB0B1B2B3000000000000, 5, -1);
        // Reset mid-SEND_KEY, then a fresh request.
        run_txn(rand128(), rand128(), 1'b1, 1, 0, 16, rand128(), 0, 7);
        run_txn(rand128(), rand128(), 1'b1, 0, 1, 16, rand128(), 0, -1);

        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 5))
                0:       nb = 0;
                1, 2:    nb = $urandom_range(1, 15);
                default: nb = 16;
            endcase
            run_txn(rand128(), rand128(), 1'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, C_T - 2), nb, rand128(), $urandom_range(0, 3), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_byte_host.md
# aes_byte_host

Host-side initiator for the AES engine's byte-serial command interface. It accepts a 128-bit plaintext and key on a valid/ready request port and serialises them onto the engine's `cmd`/`din` bus. It then issues the start command and collects the 16-byte ciphertext burst into a 128-bit response register, holding it until the consumer accepts it. It sits between system logic and `aes_engine`, replacing a hand-driven stimulus sequence.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles to wait in START for `eng_dok` before aborting with error.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_pt` in 128: plaintext; `[127:120]` is the first byte sent.
- `req_key` in 128: key; `[127:120]` is the first byte sent.
- `req_load_key` in 1: 1 means send key phase; 0 means reuse the engine's current key.
- `resp_valid` out 1: ciphertext/status valid.
- `resp_ready` in 1: consumer accepts response.
- `resp_ct` out 128: ciphertext; first received byte in `[127:120]`.
- `resp_err` out 1: timeout or short burst; qualified by `resp_valid`.
- `eng_cmd` out 2: engine command. 00 = ID, 01 = SP, 10 = SK, 11 = ST.
- `eng_din` out 8: engine data byte.
- `eng_ready` in 1: engine `interface_ready`.
- `eng_dout` in 8: engine output byte.
- `eng_dok` in 1: engine `data_ok`; one byte per cycle while high.

## Operation
- All outputs are registered.
- Request fields are latched on `req_valid && req_ready`.
- States:
  - **IDLE**: `req_ready`=1 and `eng_cmd`=ID. On accept, go to WAIT_RDY.
  - **WAIT_RDY**: `eng_cmd`=ID. On the edge where `eng_ready`=1, load `eng_cmd`=SP and `eng_din`=pt byte 0, clear the byte counter, and go to SEND_PT.
  - **SEND_PT**: the counter runs 0..15 and `eng_din` presents pt byte n, one byte per cycle with no gaps.
    - When byte 15 has been presented for one cycle and `req_load_key`=1: load SK with key byte 0 and go to SEND_KEY.
    - Otherwise: load ST and go to START.
  - **SEND_KEY**: same 16-cycle sequence with `eng_cmd`=SK. Afterwards load ST and go to START.
  - **START**: `eng_cmd`=ST is held and the timeout counter increments.
    - On the edge sampling `eng_dok`=1: shift in `eng_dout` as byte 0, load `eng_cmd`=ID, set the receive count to 1, and go to RECV.
    - At count == `TIMEOUT_CYCLES`: set `resp_err`=1 and `resp_ct`=0, and go to DONE.
  - **RECV**: `eng_cmd`=ID. Each edge with `eng_dok`=1 shifts in a byte (`ct = {ct[119:0], eng_dout}`).
    - After the 16th byte: go to DONE with `resp_err`=0.
    - If `eng_dok`=0 with fewer than 16 bytes: set `resp_err`=1, keep the partial `resp_ct`, and go to DONE.
  - **DONE**: `resp_valid`=1, `resp_ct` and `resp_err` are stable. On `resp_ready`, go to IDLE and clear `resp_valid` on that edge.
- `eng_din` is 00 whenever `eng_cmd` is ID or ST.
- The counter widths are 4-bit for bytes and $clog2(`TIMEOUT_CYCLES`+1) for the timeout. The byte counter wraps only via the state change, never free-running.
- `req_valid` outside IDLE is ignored (`req_ready`=0). New requests are not pipelined; a request is accepted only after the response is consumed.
- `eng_dok` is ignored in IDLE, WAIT_RDY, SEND_PT, SEND_KEY and DONE.
- Reset values: IDLE, `eng_cmd`=00, `eng_din`=00, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_ct`=0, all counters 0.
- Reset asserted mid-operation forces reset values on that edge, so the engine sees ID on the next cycle.

## Timing
- Accept at edge E0. If `eng_ready`=1 at E1, SP byte 0 is driven from E1, and the engine samples it at E2.
- SP occupies exactly 16 cycles (E1..E16), SK occupies E17..E32, and ST is first driven at E33.
  - With `req_load_key`=0, ST is first driven at E17.
- `eng_dok` sampled high at edge Dk means `eng_cmd`=ID from Dk. For a contiguous burst, `resp_valid` rises at Dk+15.
- `resp_valid` and `resp_ready` high at the same edge means IDLE. `req_ready`=1 from that edge, and a new request can be accepted on the next edge.
- Timeout: if no `eng_dok`, `resp_valid` rises exactly `TIMEOUT_CYCLES` edges after ST is first driven.

## Test plan
- **Full request.** Stimulus: pt=00041214120412000C00131108231919, key=2475A2B3347556883 1E2120013AA5487 (as 2475A2B334755688 31E2120013AA5487), `load_key`=1, `eng_ready`=1, and a model that asserts `eng_dok` 5 cycles after ST with bytes 00..0F. Required: SP bytes in order 00,04,12,...,19; SK bytes 24,75,...,87; `resp_ct`=000102030405060708090A0B0C0D0E0F; `resp_err`=0.
- **Key reuse.** Stimulus: `load_key`=0. Required: no SK cycle, and ST directly follows the 16th SP byte.
- **Engine not ready.** Stimulus: hold `eng_ready`=0 for 10 cycles. Required: `eng_cmd`=ID throughout, and SP starts on the first edge with `eng_ready`=1.
- **Timeout.** Stimulus: `TIMEOUT_CYCLES`=8 and `eng_dok` never asserts. Required: `resp_valid`=1, `resp_err`=1, `resp_ct`=0, 8 cycles after ST.
- **Short burst and backpressure.** Stimulus: `eng_dok` high for 10 bytes AA..B3, and `resp_ready` held low for 5 cycles. Required: `resp_err`=1, `resp_ct[79:0]`=AAAB...B3, response stable until accepted, and `req_ready`=0 throughout.
- **Reset mid-SEND_KEY.** Stimulus: assert reset during SEND_KEY. Required: reset values on the next edge, and a fresh request afterwards completes normally.
